// File: rtl/radix4_multiplier_pkg.sv
// Shared definitions for the radix-4 Booth multiplier: FSM state encodings,
// default operand width and the Booth digit control fields.
package radix4_multiplier_pkg;

    localparam int DEFAULT_W   = 8;
    localparam int BOOTH_GRP_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Booth digit magnitude/sign controls: zero -> digit 0, two -> |digit| 2,
    // neg -> digit negative.
    typedef struct packed {
        logic zero;
        logic two;
        logic neg;
    } booth_ctrl_t;

    // Number of radix-4 digits for a W-bit unsigned multiplier (one extra
    // digit absorbs the zero-extension).
    function automatic int num_digits(input int w);
        return w / 2 + 1;
    endfunction

endpackage

// File: rtl/radix4_multiplier_if.sv
// Request/result bundle between the operand source and the multiplier.
interface radix4_multiplier_if
    import radix4_multiplier_pkg::*;
#(
    parameter int W = DEFAULT_W
);
    logic           start;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic           ready;
    logic           done;
    logic [2*W-1:0] p;

    modport master (output start, output x, output y,
                    input  ready, input  done, input  p);
    modport slave  (input  start, input  x, input  y,
                    output ready, output done, output p);
endinterface

// File: rtl/radix4_multiplier_booth_encoder.sv
// Radix-4 Booth recoding of one overlapping 3-bit multiplier group.
module booth_encoder
    import radix4_multiplier_pkg::*;
(
    input  logic [BOOTH_GRP_W-1:0] grp,
    output booth_ctrl_t            ctrl
);

    // Map the group to digit 0, +-1 or +-2.
    always_comb begin
        ctrl = '0;
        case (grp)
            3'b000, 3'b111: ctrl.zero = 1'b1;
            3'b011:         ctrl.two  = 1'b1;
            3'b100: begin
                ctrl.two = 1'b1;
                ctrl.neg = 1'b1;
            end
            3'b101, 3'b110: ctrl.neg  = 1'b1;
            default:        ctrl      = '0;
        endcase
    end

endmodule

// File: rtl/radix4_multiplier.sv
// Sequential radix-4 (modified Booth) unsigned multiplier.
// One Booth digit per clock; p is held from done until the next done.
module radix4_multiplier
    import radix4_multiplier_pkg::*;
#(
    parameter int W = DEFAULT_W
)(
    input  logic                clk,
    input  logic                reset_n,
    radix4_multiplier_if.slave  bus
);

    localparam int N  = num_digits(W);
    localparam int CW = $clog2(N + 1);
    localparam int AW = 2 * W + 2;
    localparam int MW = W + 3;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   acc_q;
    logic [AW-1:0]   mcand_q;
    logic [MW-1:0]   mplier_q;
    logic [2*W-1:0]  p_q;
    booth_ctrl_t     ctrl;
    logic [AW-1:0]   pp_mag;
    logic [AW-1:0]   pp;
    logic [AW-1:0]   acc_sum;
    logic            last_digit;

    booth_encoder u_booth_encoder (
        .grp  (mplier_q[2:0]),
        .ctrl (ctrl)
    );

    assign last_digit = (cnt_q == CW'(N - 1));

    // Partial product for the current digit, added modulo 2^AW (two's complement).
    always_comb begin
        pp_mag  = ctrl.two ? {mcand_q[AW-2:0], 1'b0} : mcand_q;
        pp      = ctrl.zero ? '0 : (ctrl.neg ? ({AW{1'b0}} - pp_mag) : pp_mag);
        acc_sum = acc_q + pp;
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_CALC;
            ST_CALC: if (last_digit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand latch, shift-and-accumulate datapath and result register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            p_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        mcand_q  <= {{(AW-W){1'b0}}, bus.x};
                        mplier_q <= {2'b00, bus.y, 1'b0};
                        acc_q    <= '0;
                        cnt_q    <= '0;
                    end
                end
                ST_CALC: begin
                    acc_q    <= acc_sum;
                    mcand_q  <= {mcand_q[AW-3:0], 2'b00};
                    mplier_q <= {2'b00, mplier_q[MW-1:2]};
                    cnt_q    <= cnt_q + CW'(1);
                    if (last_digit) p_q <= acc_sum[2*W-1:0];
                end
                default: ;
            endcase
        end
    end

    assign bus.ready = (state_q == ST_IDLE);
    assign bus.done  = (state_q == ST_DONE);
    assign bus.p     = p_q;

endmodule

// File: tb/tb_radix4_multiplier.sv
// Self-checking bench for radix4_multiplier: directed vector table,
// hand-written corner sequences and random operands against x*y.
module tb_radix4_multiplier;
    import radix4_multiplier_pkg::*;

    localparam int W = DEFAULT_W;
    localparam int N = num_digits(W);

    typedef struct {
        logic [W-1:0]   x;
        logic [W-1:0]   y;
        logic [2*W-1:0] p;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_times[$];

    always #5 clk = ~clk;

    radix4_multiplier_if #(.W(W)) bus ();

    radix4_multiplier #(.W(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Cycle counter and done-pulse monitor (sampled mid-cycle).
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_times.push_back(cyc);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and wait (bounded) for done; optionally toggle
    // start/x/y while busy to show they are ignored.
    task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b, input bit noise,
                            output logic [2*W-1:0] got, output int lat);
        bus.start = 1'b1;
        bus.x = a;
        bus.y = b;
        tick();
        check("ready_low_after_accept", 64'(bus.ready), 64'd0);
        lat = 0;
        bus.start = noise ? 1'($urandom) : 1'b0;
        bus.x = W'($urandom);
        bus.y = W'($urandom);
        while (lat < 20) begin
            tick();
            lat++;
            if (bus.done === 1'b1) break;
            bus.start = noise ? 1'($urandom) : 1'b0;
            bus.x = W'($urandom);
            bus.y = W'($urandom);
        end
        bus.start = 1'b0;
        got = bus.p;
    endtask

    task automatic do_vec(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp, input bit noise);
        logic [2*W-1:0] got;
        int lat;
        int d0;
        d0 = done_cnt;
        run_mult(a, b, noise, got, lat);
        check("latency", 64'(lat), 64'(N));
        check("product", 64'(got), 64'(exp));
        tick();
        check("done_one_cycle", 64'(bus.done), 64'd0);
        check("ready_returns", 64'(bus.ready), 64'd1);
        check("single_done", 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[$];
        logic [2*W-1:0] got;
        logic [W-1:0] a, b;
        int lat, d0, first;

        vecs.push_back('{x: 8'd255, y: 8'd255, p: 16'd65025});
        vecs.push_back('{x: 8'd128, y: 8'd0,   p: 16'd0});
        vecs.push_back('{x: 8'd128, y: 8'd1,   p: 16'd128});
        vecs.push_back('{x: 8'hAA,  y: 8'h55,  p: 16'd14450});
        vecs.push_back('{x: 8'd3,   y: 8'hFF,  p: 16'd765});
        vecs.push_back('{x: 8'd7,   y: 8'd9,   p: 16'd63});
        vecs.push_back('{x: 8'd0,   y: 8'd200, p: 16'd0});
        vecs.push_back('{x: 8'h55,  y: 8'hAA,  p: 16'd14450});
        vecs.push_back('{x: 8'd255, y: 8'd1,   p: 16'd255});

        bus.start = 1'b0;
        bus.x = '0;
        bus.y = '0;

        // Reset state, then idle with no request.
        repeat (3) tick();
        check("reset_ready", 64'(bus.ready), 64'd1);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_p", 64'(bus.p), 64'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_stable", 64'({bus.ready, bus.done, bus.p}), 64'({1'b1, 1'b0, 16'd0}));
        end

        // Directed table; result must be held while idle.
        for (int i = 0; i < vecs.size(); i++) begin
            do_vec(vecs[i].x, vecs[i].y, vecs[i].p, 1'b0);
            repeat (10) tick();
            check("p_held", 64'(bus.p), 64'(vecs[i].p));
        end

        // Reset while idle clears the held product.
        reset_n = 1'b0;
        #2;
        check("idle_reset_p", 64'(bus.p), 64'd0);
        check("idle_reset_ready", 64'(bus.ready), 64'd1);
        reset_n = 1'b1;
        tick();

        // start re-pulsed during CALC is ignored.
        d0 = done_cnt;
        bus.start = 1'b1;
        bus.x = 8'd200;
        bus.y = 8'd100;
        tick();
        bus.start = 1'b0;
        bus.x = 8'd1;
        bus.y = 8'd1;
        tick();
        bus.start = 1'b1;
        tick();
        tick();
        bus.start = 1'b0;
        lat = 3;
        while (lat < 20 && bus.done !== 1'b1) begin
            tick();
            lat++;
        end
        check("repulse_latency", 64'(lat), 64'(N));
        check("repulse_p", 64'(bus.p), 64'd20000);
        repeat (10) tick();
        check("repulse_single_done", 64'(done_cnt - d0), 64'd1);
        check("repulse_p_held", 64'(bus.p), 64'd20000);
        do_vec(8'd1, 8'd1, 16'd1, 1'b0);
        check("repulse_second_done", 64'(done_cnt - d0), 64'd2);

        // Reset on the third CALC cycle aborts without done.
        d0 = done_cnt;
        bus.start = 1'b1;
        bus.x = 8'd200;
        bus.y = 8'd100;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check("abort_ready", 64'(bus.ready), 64'd1);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_p", 64'(bus.p), 64'd0);
        #2;
        reset_n = 1'b1;
        repeat (10) tick();
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        check("abort_p_after", 64'(bus.p), 64'd0);
        do_vec(8'd7, 8'd9, 16'd63, 1'b0);

        // start held high: one result every N+2 cycles.
        first = done_times.size();
        bus.start = 1'b1;
        bus.x = 8'd13;
        bus.y = 8'd11;
        repeat (3 * (N + 2) + 1) tick();
        bus.start = 1'b0;
        repeat (N + 4) tick();
        check("b2b_count", 64'(done_times.size() - first), 64'd4);
        for (int i = first + 1; i < done_times.size(); i++)
            check("b2b_spacing", 64'(done_times[i] - done_times[i-1]), 64'(N + 2));
        check("b2b_p", 64'(bus.p), 64'd143);

        // Random operands with busy-time noise against plain x*y.
        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            if (i % 50 == 0) a = '1;
            if (i % 70 == 0) b = '1;
            do_vec(a, b, (2*W)'(a) * (2*W)'(b), 1'b1);
            if ($urandom_range(0, 3) == 0) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
